// File: rtl/trace_cmd_sequencer_if.sv
// Record-input and LLC command/response signals of trace_cmd_sequencer.
// master = stimulus source plus LLC model, slave = the sequencer itself.
interface trace_cmd_sequencer_if #(
  parameter int CMD_W  = 4,
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [CMD_W-1:0]  in_cmd;
  logic [ADDR_W-1:0] in_addr;
  logic              llc_valid;
  logic              llc_ready;
  logic [CMD_W-1:0]  llc_cmd;
  logic [ADDR_W-1:0] llc_addr;
  logic              llc_rsp_valid;
  logic              llc_rsp_hit;

  modport master (
    output in_valid, in_cmd, in_addr, llc_ready, llc_rsp_valid, llc_rsp_hit,
    input  in_ready, llc_valid, llc_cmd, llc_addr
  );

  modport slave (
    input  in_valid, in_cmd, in_addr, llc_ready, llc_rsp_valid, llc_rsp_hit,
    output in_ready, llc_valid, llc_cmd, llc_addr
  );
endinterface

// File: rtl/trace_cmd_sequencer.sv
// Buffers trace records, issues them to the LLC one at a time, keeps
// read/write/hit/miss statistics and a per-mille hit ratio.
module trace_cmd_sequencer #(
  parameter int CMD_W  = 4,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  trace_cmd_sequencer_if.slave     bus,
  input  logic                     mode_silent,
  output logic                     print_req,
  output logic [CNT_W-1:0]         reads,
  output logic [CNT_W-1:0]         writes,
  output logic [CNT_W-1:0]         hits,
  output logic [CNT_W-1:0]         misses,
  output logic [9:0]               ratio_pm,
  output logic                     ratio_valid,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);
  localparam int PW    = $clog2(DEPTH);
  localparam int NUM_W = CNT_W + 10;
  localparam int DEN_W = CNT_W + 1;
  localparam int DCW   = $clog2(NUM_W);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] DIV      = 2'd3;

  localparam logic [CMD_W-1:0] CMD_WR       = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_LAST_RW  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_LAST_LLC = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_CLEAR    = CMD_W'(8);
  localparam logic [CMD_W-1:0] CMD_PRINT    = CMD_W'(9);
  localparam logic [NUM_W-1:0] PM_SCALE     = NUM_W'(1000);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------- record FIFO ----------------
  logic [CMD_W-1:0]  cmd_mem  [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]       count_reg, count_next;
  logic              in_ready_reg;
  logic              push, pop;
  logic [CMD_W-1:0]  head_cmd;
  logic [ADDR_W-1:0] head_addr;

  logic [1:0]        state_reg;

  assign push      = bus.in_valid && in_ready_reg;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign head_cmd  = cmd_mem[rd_ptr_reg];
  assign head_addr = addr_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (PW+1)'(1);
    else if (pop && !push)
      count_next = count_reg - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr_reg]  <= bus.in_cmd;
      addr_mem[wr_ptr_reg] <= bus.in_addr;
    end
  end

  // in_ready is held low through reset and rises on the first clock after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg    <= count_next;
      in_ready_reg <= (count_next < (PW+1)'(DEPTH));
    end
  end

  // ---------------- sequencer and statistics ----------------
  logic              llc_valid_reg;
  logic [CMD_W-1:0]  llc_cmd_reg;
  logic [ADDR_W-1:0] llc_addr_reg;
  logic              print_req_reg;
  logic [CNT_W-1:0]  reads_reg, writes_reg, hits_reg, misses_reg, drop_cnt_reg;
  logic [9:0]        ratio_pm_reg;
  logic              ratio_valid_reg;

  logic [NUM_W-1:0]  div_q_reg;
  logic [DEN_W-1:0]  div_r_reg;
  logic [DEN_W-1:0]  div_d_reg;
  logic [DCW-1:0]    div_cnt_reg;

  logic              head_issue, head_print, head_drop;
  logic              rsp_rw;
  logic [CNT_W-1:0]  hits_upd, misses_upd;
  logic [DEN_W-1:0]  den_init;
  logic [NUM_W-1:0]  num_init;
  logic [DEN_W:0]    rem_shift;
  logic              step_ge;
  logic [DEN_W-1:0]  rem_step;
  logic [NUM_W-1:0]  q_step;

  // Command 7 is neither an LLC command nor illegal: it is consumed silently.
  assign head_issue = (head_cmd <= CMD_LAST_LLC) || (head_cmd == CMD_CLEAR);
  assign head_print = (head_cmd == CMD_PRINT);
  assign head_drop  = (head_cmd > CMD_PRINT);

  assign rsp_rw     = (llc_cmd_reg <= CMD_LAST_RW);
  assign hits_upd   = (rsp_rw && bus.llc_rsp_hit)  ? sat_inc(hits_reg)   : hits_reg;
  assign misses_upd = (rsp_rw && !bus.llc_rsp_hit) ? sat_inc(misses_reg) : misses_reg;
  assign den_init   = {1'b0, hits_upd} + {1'b0, misses_upd};
  assign num_init   = NUM_W'(hits_upd) * PM_SCALE;

  // One restoring-division step; the remainder never exceeds the divisor,
  // so the subtraction is exact in DEN_W bits.
  assign rem_shift  = {div_r_reg, div_q_reg[NUM_W-1]};
  assign step_ge    = (rem_shift >= {1'b0, div_d_reg});
  assign rem_step   = step_ge ? (rem_shift[DEN_W-1:0] - div_d_reg) : rem_shift[DEN_W-1:0];
  assign q_step     = {div_q_reg[NUM_W-2:0], step_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      llc_valid_reg   <= 1'b0;
      llc_cmd_reg     <= '0;
      llc_addr_reg    <= '0;
      print_req_reg   <= 1'b0;
      reads_reg       <= '0;
      writes_reg      <= '0;
      hits_reg        <= '0;
      misses_reg      <= '0;
      drop_cnt_reg    <= '0;
      ratio_pm_reg    <= '0;
      ratio_valid_reg <= 1'b1;
      div_q_reg       <= '0;
      div_r_reg       <= '0;
      div_d_reg       <= '0;
      div_cnt_reg     <= '0;
    end else begin
      print_req_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            if (head_issue) begin
              state_reg     <= ISSUE;
              llc_valid_reg <= 1'b1;
              llc_cmd_reg   <= head_cmd;
              llc_addr_reg  <= head_addr;
            end else if (head_print) begin
              print_req_reg <= !mode_silent;
            end else if (head_drop) begin
              drop_cnt_reg  <= sat_inc(drop_cnt_reg);
            end
          end
        end
        ISSUE: begin
          if (bus.llc_ready) begin
            llc_valid_reg <= 1'b0;
            state_reg     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (bus.llc_rsp_valid) begin
            if (llc_cmd_reg == CMD_CLEAR) begin
              reads_reg       <= '0;
              writes_reg      <= '0;
              hits_reg        <= '0;
              misses_reg      <= '0;
              drop_cnt_reg    <= '0;
              ratio_pm_reg    <= '0;
              ratio_valid_reg <= 1'b1;
              state_reg       <= IDLE;
            end else if (rsp_rw) begin
              if (llc_cmd_reg == CMD_WR)
                writes_reg <= sat_inc(writes_reg);
              else
                reads_reg  <= sat_inc(reads_reg);
              hits_reg        <= hits_upd;
              misses_reg      <= misses_upd;
              div_q_reg       <= num_init;
              div_r_reg       <= '0;
              div_d_reg       <= den_init;
              div_cnt_reg     <= '0;
              ratio_valid_reg <= 1'b0;
              state_reg       <= DIV;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DIV: begin
          div_q_reg   <= q_step;
          div_r_reg   <= rem_step;
          div_cnt_reg <= div_cnt_reg + DCW'(1);
          if (div_cnt_reg == DCW'(NUM_W - 1)) begin
            // The quotient is at most 1000, so the low 10 bits hold it.
            ratio_pm_reg    <= (div_d_reg == '0) ? 10'd0 : q_step[9:0];
            ratio_valid_reg <= 1'b1;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.llc_valid = llc_valid_reg;
  assign bus.llc_cmd   = llc_cmd_reg;
  assign bus.llc_addr  = llc_addr_reg;
  assign print_req     = print_req_reg;
  assign reads         = reads_reg;
  assign writes        = writes_reg;
  assign hits          = hits_reg;
  assign misses        = misses_reg;
  assign drop_cnt      = drop_cnt_reg;
  assign ratio_pm      = ratio_pm_reg;
  assign ratio_valid   = ratio_valid_reg;
  assign fifo_count    = count_reg;
  assign busy          = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: doc/trace_cmd_sequencer.md
Name: trace_cmd_sequencer

Overview:
- Clocked, parametrised successor to the behavioural trace-file driver.
- Accepts decoded trace records (command, address) from a file reader or upstream stimulus source and buffers them in a FIFO.
- Issues each record to the LLC over a valid/ready handshake, waits for the LLC response, then updates read/write/hit/miss statistics.
- Computes the hit ratio in per-mille with an iterative divider; handles clear (8), print (9) and illegal commands itself.

Parameters:
- CMD_W, 4, trace command width.
- ADDR_W, 32, address width.
- DEPTH, 8, record FIFO depth (power of 2, ≥2).
- CNT_W, 32, width of every statistics counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  record present.
- in_ready  out  1  FIFO can accept a record.
- in_cmd  in  CMD_W  trace command.
- in_addr  in  ADDR_W  trace address.
- mode_silent  in  1  1 = silent mode (suppress print requests), 0 = normal mode.
- llc_valid  out  1  command offered to LLC.
- llc_ready  in  1  LLC accepts the command.
- llc_cmd  out  CMD_W  command to LLC.
- llc_addr  out  ADDR_W  address to LLC.
- llc_rsp_valid  in  1  LLC finished the accepted command (1-cycle pulse).
- llc_rsp_hit  in  1  1 = hit, 0 = miss; qualified by llc_rsp_valid.
- print_req  out  1  1-cycle pulse requesting a cache-content dump.
- reads  out  CNT_W  count of retired cmds 0 and 2.
- writes  out  CNT_W  count of retired cmd 1.
- hits  out  CNT_W  hits on retired cmds 0–2.
- misses  out  CNT_W  misses on retired cmds 0–2.
- ratio_pm  out  10  hit ratio, 0..1000 per-mille.
- ratio_valid  out  1  ratio_pm is up to date.
- drop_cnt  out  CNT_W  count of illegal commands (>9) discarded.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (asynchronous, immediate): FIFO emptied; FSM to IDLE.
  - All counters, ratio_pm, llc_valid, print_req, busy and fifo_count = 0.
  - ratio_valid = 1; in_ready = 1 one cycle after deassertion.
  - Reset mid-handshake drops llc_valid at once; a late llc_rsp_valid arriving in IDLE is ignored.
- FIFO:
  - Push on in_valid && in_ready; in_ready = (fifo_count < DEPTH), driven from registers only.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Record order is preserved.
- FSM states: IDLE, ISSUE, WAIT_RSP, DIV.
  - IDLE with FIFO non-empty: pop the head record, then:
    - cmd 0–6 or 8 → ISSUE, with llc_valid=1 and llc_cmd/llc_addr registered from the head.
    - cmd 9 → print_req pulses the next cycle if mode_silent=0; stays IDLE, not sent to LLC.
    - cmd >9 → drop_cnt+1; stays IDLE.
    - Each case consumes one cycle per record.
  - ISSUE: hold llc_valid, llc_cmd and llc_addr stable until llc_ready; on llc_valid && llc_ready → WAIT_RSP, llc_valid=0 the next cycle.
  - WAIT_RSP: on llc_rsp_valid:
    - cmd 0/2: reads+1. cmd 1: writes+1. cmds 0–2: hits+1 or misses+1 per llc_rsp_hit; then → DIV.
    - cmds 3–6: no counter change → IDLE.
    - cmd 8: reads, writes, hits, misses, drop_cnt and ratio_pm cleared to 0, ratio_valid=1 → IDLE.
    - No timeout.
  - DIV: ratio_valid=0.
    - Restoring divider computes floor(hits*1000 / (hits+misses)) from the updated counters.
    - Numerator width CNT_W+10; denominator width CNT_W+1.
    - Takes exactly CNT_W+10 cycles; then ratio_pm loads, ratio_valid=1 → IDLE.
    - Records keep queueing in the FIFO during DIV.
- Counters saturate at 2^CNT_W−1; no wrap.
- Hits+misses is never zero in DIV; the divider still returns 0 on a zero denominator.
- Minimum latency, pop to llc_valid: 1 cycle.

Test Plan:
- Reset, then push {0,0x100}; LLC ready with zero wait, rsp hit after 3 cycles → reads=1, hits=1, ratio_pm=1000, ratio_valid low for exactly 42 cycles (CNT_W=32).
- Records 0 hit, 1 miss, 2 miss → reads=2, writes=1, hits=1, misses=2, ratio_pm=333.
- llc_ready held low 20 cycles while 10 records arrive → in_ready=0 once fifo_count=8, llc_cmd/llc_addr stable throughout, no record lost or reordered.
- Records 9 (mode_silent=0), 9 (mode_silent=1), 12 → exactly one print_req pulse, drop_cnt=1, llc_valid never asserted.
- After 5 hits, cmd 8 with rsp → all statistics 0, ratio_pm=0, ratio_valid=1; next read miss → ratio_pm=0.
- Assert reset while in ISSUE with 4 records queued → llc_valid=0 immediately, fifo_count=0, counters 0, then clean restart.
